// File: rtl/sort_controller.sv
// Bubble-sort sequencer that borrows a single-port RAM (sync write, comb read)
// from the host, sorts all 2**ADDR_WIDTH words in place, then hands it back.
//
// state | meaning
// IDLE  | host owns RAM port, waiting for start
// RD_A  | read word j into a
// RD_B  | read word j+1 into b
// CMP   | decide whether the pair is out of order
// WR_A  | write b to j
// WR_B  | write a to j+1, flag pass as having swapped
// DONE  | one-cycle completion pulse, host owns port
module sort_controller #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 8,
   parameter bit DESCENDING = 1'b0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   output logic                  o_busy,
   output logic                  o_done,
   input  logic                  i_host_we,
   input  logic [ADDR_WIDTH-1:0] i_host_addr,
   input  logic [DATA_WIDTH-1:0] i_host_din,
   output logic [DATA_WIDTH-1:0] o_host_dout,
   output logic                  o_ram_we,
   output logic [ADDR_WIDTH-1:0] o_ram_addr,
   output logic [DATA_WIDTH-1:0] o_ram_din,
   input  logic [DATA_WIDTH-1:0] i_ram_dout
);

   localparam int N = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(N - 2);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_A, S_RD_B, S_CMP, S_WR_A, S_WR_B, S_DONE
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_j, w_j_nxt;
   logic [ADDR_WIDTH-1:0] r_p, w_p_nxt;
   logic [DATA_WIDTH-1:0] r_a, w_a_nxt;
   logic [DATA_WIDTH-1:0] r_b, w_b_nxt;
   logic                  r_swapped, w_swapped_nxt;

   logic                  w_swap_needed;
   logic                  w_advance;
   logic                  w_swapped_eff;
   logic [ADDR_WIDTH-1:0] w_j_inc;
   logic [ADDR_WIDTH:0]   w_j_plus_p;

   assign w_swap_needed = DESCENDING ? (r_a < r_b) : (r_a > r_b);
   assign w_j_inc       = r_j + ADDR_WIDTH'(1);
   // j < N-2-p rewritten as j+p < N-2 so nothing underflows
   assign w_j_plus_p    = {1'b0, r_j} + {1'b0, r_p};
   assign w_swapped_eff = r_swapped | (r_state == S_WR_B);

   assign o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
   assign o_done      = (r_state == S_DONE);
   assign o_host_dout = i_ram_dout;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state   <= S_IDLE;
         r_j       <= '0;
         r_p       <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_swapped <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_j       <= w_j_nxt;
         r_p       <= w_p_nxt;
         r_a       <= w_a_nxt;
         r_b       <= w_b_nxt;
         r_swapped <= w_swapped_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_j_nxt       = r_j;
      w_p_nxt       = r_p;
      w_a_nxt       = r_a;
      w_b_nxt       = r_b;
      w_swapped_nxt = r_swapped;
      w_advance     = 1'b0;
      o_ram_we      = 1'b0;
      o_ram_addr    = r_j;
      o_ram_din     = r_b;

      case (r_state)
         S_IDLE: begin
            o_ram_we   = i_host_we;
            o_ram_addr = i_host_addr;
            o_ram_din  = i_host_din;
            if (i_start) begin
               w_j_nxt       = '0;
               w_p_nxt       = '0;
               w_swapped_nxt = 1'b0;
               w_state_nxt   = S_RD_A;
            end
         end
         S_RD_A: begin
            w_a_nxt     = i_ram_dout;
            w_state_nxt = S_RD_B;
         end
         S_RD_B: begin
            o_ram_addr  = w_j_inc;
            w_b_nxt     = i_ram_dout;
            w_state_nxt = S_CMP;
         end
         S_CMP: begin
            if (w_swap_needed) w_state_nxt = S_WR_A;
            else               w_advance   = 1'b1;
         end
         S_WR_A: begin
            o_ram_we    = 1'b1;
            o_ram_din   = r_b;
            w_state_nxt = S_WR_B;
         end
         S_WR_B: begin
            o_ram_we      = 1'b1;
            o_ram_addr    = w_j_inc;
            o_ram_din     = r_a;
            w_swapped_nxt = 1'b1;
            w_advance     = 1'b1;
         end
         S_DONE: begin
            o_ram_we    = i_host_we;
            o_ram_addr  = i_host_addr;
            o_ram_din   = i_host_din;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_advance) begin
         if (w_j_plus_p < LAST) begin
            w_j_nxt     = w_j_inc;
            w_state_nxt = S_RD_A;
         end else if (!w_swapped_eff || ({1'b0, r_p} == LAST)) begin
            w_state_nxt = S_DONE;
         end else begin
            w_p_nxt       = r_p + ADDR_WIDTH'(1);
            w_j_nxt       = '0;
            w_swapped_nxt = 1'b0;
            w_state_nxt   = S_RD_A;
         end
      end
   end

endmodule

// File: tb/tb_sort_controller.sv
// Scoreboard bench: two sorters (ascending, descending) each on a 4x8 RAM model;
// expected cycle counts and results come from a plain bubble-sort reference.
module tb_sort_controller;

   typedef struct {
      int    unit;
      int    val;
      string name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start     [2];
   logic       host_we   [2];
   logic [1:0] host_addr [2];
   logic [7:0] host_din  [2];
   logic [7:0] host_dout [2];
   logic       busy      [2];
   logic       done      [2];
   logic       ram_we    [2];
   logic [1:0] ram_addr  [2];
   logic [7:0] ram_din   [2];
   logic [7:0] ram_dout  [2];
   logic       rd_valid  [2];

   int   total = 0;
   int   bad   = 0;
   int   busy_cnt [2];
   int   we_cnt   [2];
   exp_t exp_q [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_unit
      logic [7:0] mem [4];
      always @(posedge clk) if (ram_we[g]) mem[ram_addr[g]] <= ram_din[g];
      assign ram_dout[g] = mem[ram_addr[g]];

      sort_controller #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .DESCENDING(g == 1)) dut (
         .i_clk       (clk),
         .i_rst       (rst_n),
         .i_start     (start[g]),
         .o_busy      (busy[g]),
         .o_done      (done[g]),
         .i_host_we   (host_we[g]),
         .i_host_addr (host_addr[g]),
         .i_host_din  (host_din[g]),
         .o_host_dout (host_dout[g]),
         .o_ram_we    (ram_we[g]),
         .o_ram_addr  (ram_addr[g]),
         .o_ram_din   (ram_din[g]),
         .i_ram_dout  (ram_dout[g])
      );
   end

   // Reference: textbook bubble sort with early exit; 3 cycles per compare, +2 per swap.
   function automatic void model(input int unsigned v[4], input bit desc,
                                 output int unsigned r[4], output int cyc, output int wes);
      int unsigned t;
      bit sw;
      r = v; cyc = 0; wes = 0;
      for (int p = 0; p <= 2; p++) begin
         sw = 1'b0;
         for (int j = 0; j <= 2 - p; j++) begin
            if (desc ? (r[j] < r[j+1]) : (r[j] > r[j+1])) begin
               t = r[j]; r[j] = r[j+1]; r[j+1] = t;
               sw = 1'b1; cyc += 5; wes += 2;
            end else begin
               cyc += 3;
            end
         end
         if (!sw) break;
      end
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic check_pop(input int u, input string name, input int act);
      exp_t e;
      total++;
      if (exp_q.size() == 0 || exp_q[0].unit != u || exp_q[0].name != name) begin
         bad++;
         $display("FAIL unexpected_%s unit%0d actual=%0d (no matching expectation)", name, u, act);
      end else begin
         e = exp_q.pop_front();
         if (act != e.val) begin
            bad++;
            $display("FAIL %s unit%0d actual=%0d expected=%0d", name, u, act, e.val);
         end
      end
   endtask

   // Monitor: counts busy/write cycles per sort and checks on done pulses and readbacks.
   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (done[u]) begin
            check_pop(u, "busy_cycles", busy_cnt[u]);
            check_pop(u, "we_cycles", we_cnt[u]);
            busy_cnt[u] = 0;
            we_cnt[u]   = 0;
         end else if (busy[u]) begin
            busy_cnt[u]++;
            if (ram_we[u]) we_cnt[u]++;
         end else begin
            busy_cnt[u] = 0;
            we_cnt[u]   = 0;
         end
         if (rd_valid[u]) check_pop(u, "readback", int'(host_dout[u]));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input int u, input int a, input int unsigned d);
      host_we[u]   = 1'b1;
      host_addr[u] = a[1:0];
      host_din[u]  = d[7:0];
      step();
      host_we[u]   = 1'b0;
   endtask

   task automatic expect_read(input int u, input int a, input int unsigned d);
      exp_q.push_back('{u, int'(d), "readback"});
      host_addr[u] = a[1:0];
      rd_valid[u]  = 1'b1;
      step();
      rd_valid[u]  = 1'b0;
   endtask

   task automatic pulse_start(input int u);
      start[u] = 1'b1;
      step();
      start[u] = 1'b0;
   endtask

   task automatic wait_done(input int u);
      int n = 0;
      while (!done[u] && n < 2000) begin
         step();
         n++;
      end
      total++;
      if (!done[u]) begin
         bad++;
         $display("FAIL done_timeout unit%0d actual=no_done required=done", u);
      end
   endtask

   task automatic run_sort(input int u, input int unsigned arr[4], input bit interfere);
      int unsigned res[4];
      int cyc, wes;
      for (int i = 0; i < 4; i++) host_write(u, i, arr[i]);
      model(arr, u == 1, res, cyc, wes);
      exp_q.push_back('{u, cyc, "busy_cycles"});
      exp_q.push_back('{u, wes, "we_cycles"});
      pulse_start(u);
      if (interfere) begin
         step();
         step();
         host_we[u]   = 1'b1;
         host_addr[u] = 2'd0;
         host_din[u]  = 8'hAA;
         start[u]     = 1'b1;
         step();
         host_we[u]   = 1'b0;
         start[u]     = 1'b0;
      end
      wait_done(u);
      step();
      for (int i = 0; i < 4; i++) expect_read(u, i, res[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned arr[4];
      for (int u = 0; u < 2; u++) begin
         start[u] = 1'b0; host_we[u] = 1'b0; host_addr[u] = '0; host_din[u] = '0;
         rd_valid[u] = 1'b0; busy_cnt[u] = 0; we_cnt[u] = 0;
      end
      rst_n = 1'b0;
      step();
      step();
      chk("reset_busy0", int'(busy[0]), 0);
      chk("reset_done0", int'(done[0]), 0);
      chk("reset_busy1", int'(busy[1]), 0);
      rst_n = 1'b1;
      step();

      run_sort(0, '{4, 3, 2, 1}, 1'b0);
      run_sort(0, '{1, 2, 3, 4}, 1'b0);
      run_sort(0, '{2, 1, 2, 1}, 1'b0);
      run_sort(0, '{5, 5, 5, 5}, 1'b0);
      run_sort(0, '{4, 3, 2, 1}, 1'b1);
      run_sort(1, '{8'h00, 8'hFF, 8'h7F, 8'h80}, 1'b0);

      // Async reset in busy cycle 7 (RD_B of the second compare).
      for (int i = 0; i < 4; i++) host_write(0, i, 4 - i);
      pulse_start(0);
      for (int i = 0; i < 6; i++) step();
      chk("busy_before_reset", int'(busy[0]), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("busy_in_reset", int'(busy[0]), 0);
      chk("done_in_reset", int'(done[0]), 0);
      step();
      rst_n = 1'b1;
      step();
      expect_read(0, 0, 3);
      expect_read(0, 1, 4);
      expect_read(0, 2, 2);
      expect_read(0, 3, 1);
      run_sort(0, '{3, 4, 2, 1}, 1'b0);

      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < 4; i++)
            arr[i] = (k < 3) ? $urandom_range(0, 3) : $urandom_range(0, 255);
         run_sort(k % 2, arr, 1'b0);
      end

      step();
      step();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sort_controller.md
Name: sort_controller

Overview:
- Bubble-sort sequencer for the single-port sorting RAM (synchronous write, combinational read).
- Arbitrates the RAM port between a host and the sort engine:
  - While idle, host accesses pass straight through to the RAM.
  - On start, the engine takes the port and sorts all 2**ADDR_WIDTH entries in place.
  - The engine returns the port and pulses done.

Parameters:
ADDR_WIDTH, 2, RAM address width; N = 2**ADDR_WIDTH entries, ADDR_WIDTH >= 1
DATA_WIDTH, 8, RAM word width; entries compared as unsigned
DESCENDING, 0, 0 = ascending result, 1 = descending result

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset (asserted when 0)
start  in  1  sort request, sampled only in IDLE
busy  out  1  engine owns the RAM port
done  out  1  one-cycle pulse when sort complete
host_we  in  1  host write enable
host_addr  in  ADDR_WIDTH  host address
host_din  in  DATA_WIDTH  host write data
host_dout  out  DATA_WIDTH  always equals ram_dout
ram_we  out  1  to RAM write enable
ram_addr  out  ADDR_WIDTH  to RAM address
ram_din  out  DATA_WIDTH  to RAM write data
ram_dout  in  DATA_WIDTH  from RAM, combinational on ram_addr

Behaviour:
- Reset (rst=0, async): state IDLE, busy=0, done=0, all internal registers 0. RAM contents untouched.
- Port mux:
  - In IDLE and DONE: ram_we/ram_addr/ram_din = host_we/host_addr/host_din.
  - In all other states the engine drives the port; host_we is ignored (no RAM write).
- busy=1 in every state except IDLE and DONE. done=1 only in DONE.
- Registers:
  - j: inner index, ADDR_WIDTH bits.
  - p: pass count, ADDR_WIDTH bits.
  - a, b: operand latches, DATA_WIDTH bits.
  - swapped: 1-bit flag.
- Swap condition:
  - Ascending: a > b unsigned.
  - Descending: a < b.
  - Strict comparison, so equal values are never swapped.
- States:
  - IDLE: if start, clear j, p and swapped, go to RD_A; otherwise stay.
  - RD_A: ram_addr=j, ram_we=0; latch a <= ram_dout; go to RD_B.
  - RD_B: ram_addr=j+1, ram_we=0; latch b <= ram_dout; go to CMP.
  - CMP: ram_we=0. If swap needed, go to WR_A. Otherwise advance (below).
  - WR_A: ram_we=1, ram_addr=j, ram_din=b; go to WR_B.
  - WR_B: ram_we=1, ram_addr=j+1, ram_din=a; set swapped; advance.
  - Advance:
    - If j < N-2-p: j++, go to RD_A.
    - Else (end of pass): if the pass had no swap (swapped, including a WR_B set this cycle, is 0) or p == N-2, go to DONE.
    - Else: p++, j=0, swapped=0, go to RD_A.
  - DONE: one cycle, done=1; go to IDLE. A start in DONE is ignored.
- Latency:
  - A compare with no swap costs 3 cycles; a compare with swap costs 5 cycles.
  - Busy duration is the sum over all compares. done is asserted in the cycle after the last busy cycle.
- start while busy or in DONE: ignored, not queued.
- N=2: a single compare at j=0, then DONE.
- Reset mid-sort: immediate return to IDLE with busy=0 and done=0. The RAM is left partially sorted and no rollback is performed. A new start re-sorts from scratch.
- Port behaviour while busy:
  - Host writes are dropped, not delayed.
  - host_dout reflects whatever address the engine is driving.

Test Plan:
- Host writes 4,3,2,1 to addresses 0..3, then start → busy for exactly 30 cycles (6 swaps, 3 passes), done pulses 1 cycle, readback 1,2,3,4, exactly 12 ram_we cycles observed.
- Preload 1,2,3,4, then start → 9 busy cycles, ram_we never 1 while busy, done pulse, contents unchanged.
- Preload 2,1,2,1 → result 1,1,2,2. Preload 5,5,5,5 → 9 busy cycles, no writes (equal values not swapped).
- Preload 4,3,2,1, start, then during busy host_we=1 addr=0 din=0xAA plus a second start → write dropped, second start ignored, result 1,2,3,4, single done pulse.
- Preload 4,3,2,1, start, assert rst=0 asynchronously at busy cycle 7 → busy/done fall immediately. Release reset and start again → final 1,2,3,4.
- DESCENDING=1, preload 0x00,0xFF,0x7F,0x80 → result 0xFF,0x80,0x7F,0x00 (unsigned compare), done asserted.
